// File: rtl/dual_port_ram_16x8.sv
// Simple dual-port synchronous RAM, 16x8, one write port and one registered read port.
// Optional macro DUALRAM_WRITE_FIRST_EN selects write-through on same-address read/write.
module dual_port_ram_16x8 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              we,
    input  logic              re
);

`ifdef DUALRAM_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    // Address space must be fully populated; there is no out-of-range handling.
    if (DEPTH != (32'd1 << ADDR_W)) begin : g_depth_check
        $error("dual_port_ram_16x8: DEPTH must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              same_addr_c;

    assign same_addr_c = (rd_addr == wr_addr);

    // Next-state: the read samples the pre-write array, so read-first falls out naturally.
    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
        if (we) begin
            mem_d[wr_addr] = din;
        end
        if (re) begin
            if (WRITE_FIRST && we && same_addr_c) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[rd_addr];
            end
        end
    end

    // Synchronous reset clears the whole array and drops any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_dual_port_ram_16x8.sv
// Self-checking bench for dual_port_ram_16x8: directed plan steps plus randomized traffic
// compared against an array-based reference memory.
module tb_dual_port_ram_16x8;

`ifdef DUALRAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] rd_addr;
    logic [3:0] wr_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] ref_dout;
    bit         ref_known = 1'b0;

    dual_port_ram_16x8 dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .dout   (dout),
        .rd_addr(rd_addr),
        .wr_addr(wr_addr),
        .we     (we),
        .re     (re)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Apply current inputs for one edge, advance the reference, then compare dout.
    task automatic tick(input string tag);
        logic [7:0] rd_val;
        if (rst) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
            ref_dout  = 8'h00;
            ref_known = 1'b1;
        end else begin
            rd_val = ref_mem[rd_addr];
            if (re) ref_dout = (WF && we && rd_addr == wr_addr) ? din : rd_val;
            if (we) ref_mem[wr_addr] = din;
        end
        @(posedge clk);
        #1;
        if (ref_known) check_eq(tag, dout, ref_dout);
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] wa, input logic [7:0] d,
                         input logic rr, input logic [3:0] ra, input string tag);
        rst = r; we = w; wr_addr = wa; din = d; re = rr; rd_addr = ra;
        tick(tag);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; din = '0; rd_addr = '0; wr_addr = '0;
        @(negedge clk);

        // 1: reset then read every address
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, "reset");
        check_eq("reset_dout", dout, 8'h00);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(a), "reset_read");
            check_eq("reset_read_const", dout, 8'h00);
        end

        // 2: write then read
        drive(1'b0, 1'b1, 4'hB, 8'hA5, 1'b0, 4'h0, "wr_B");
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hB, "rd_B");
        check_eq("rd_B_const", dout, 8'hA5);

        // 3: hold with re=0, then read address 3
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h3, "hold");
        check_eq("hold_const", dout, 8'hA5);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3, "rd_3");
        check_eq("rd_3_const", dout, 8'h00);

        // 4: concurrent different addresses
        drive(1'b0, 1'b1, 4'h2, 8'h3C, 1'b1, 4'hB, "concurrent");
        check_eq("concurrent_const", dout, 8'hA5);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h2, "rd_2");
        check_eq("rd_2_const", dout, 8'h3C);

        // 5: same-address collision
        drive(1'b0, 1'b1, 4'h5, 8'h11, 1'b0, 4'h0, "wr_5");
        drive(1'b0, 1'b1, 4'h5, 8'h77, 1'b1, 4'h5, "collide");
        check_eq("collide_const", dout, WF ? 8'h77 : 8'h11);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h5, "rd_5");
        check_eq("rd_5_const", dout, 8'h77);

        // 6: fill, then reset during a write
        for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 4'(a), 8'hF0 + 8'(a), 1'b0, 4'h0, "fill");
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hE, "rd_fill");
        check_eq("rd_fill_const", dout, 8'hFE);
        drive(1'b1, 1'b1, 4'h7, 8'h99, 1'b1, 4'h7, "reset_mid");
        check_eq("reset_mid_const", dout, 8'h00);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(a), "post_reset_read");
            check_eq("post_reset_const", dout, 8'h00);
        end

        // Randomized traffic with dense address collisions and occasional reset
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            we  = $urandom_range(0, 1) == 1;
            re  = $urandom_range(0, 2) != 0;
            wr_addr = we ? 4'($urandom_range(0, 15)) : 4'bxxxx;
            din     = we ? 8'($urandom) : 8'bxxxxxxxx;
            rd_addr = re ? (($urandom_range(0, 3) == 0 && we) ? wr_addr : 4'($urandom_range(0, 15)))
                         : 4'bxxxx;
            tick("random");
        end

        // Final sweep of the whole array
        for (int a = 0; a < 16; a++) drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(a), "final_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
